// File: rtl/avalon_st_channel_demux.sv
// Channel demultiplexer for a tagged Avalon-ST stream: routes each packet to out0 or out1
// by the SOP-beat channel, with a small FIFO per output and a saturating drop counter.
module avalon_st_channel_demux #(
  parameter int unsigned DATA_WIDTH = 72,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [DATA_WIDTH-1:0] demux_in_data,
  input  logic                  demux_in_channel,
  input  logic                  demux_in_startofpacket,
  input  logic                  demux_in_endofpacket,
  input  logic                  demux_in_valid,
  output logic                  demux_in_ready,
  output logic [DATA_WIDTH-1:0] demux_out0_data,
  output logic                  demux_out0_startofpacket,
  output logic                  demux_out0_endofpacket,
  output logic                  demux_out0_valid,
  input  logic                  demux_out0_ready,
  output logic [DATA_WIDTH-1:0] demux_out1_data,
  output logic                  demux_out1_startofpacket,
  output logic                  demux_out1_endofpacket,
  output logic                  demux_out1_valid,
  input  logic                  demux_out1_ready,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic                  demux_busy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW = PtrW + 1;
  localparam int unsigned EntW = DATA_WIDTH + 2;

  typedef enum logic [0:0] {StIdle, StPkt} state_e;

  state_e               state_q, state_d;
  logic                 lock_q, lock_d;
  logic [CNT_WIDTH-1:0] drop_q;
  logic                 orphan, target, accept, drop_inc;
  logic [1:0]           push, pop, full, not_empty, out_ready;
  logic [EntW-1:0]      head [2];

  assign out_ready = {demux_out1_ready, demux_out0_ready};

  always_comb begin
    orphan   = (state_q == StIdle) && !demux_in_startofpacket;
    target   = (state_q == StPkt && !demux_in_startofpacket) ? lock_q : demux_in_channel;
    // Orphans are swallowed regardless of FIFO state so they can never stall the input.
    demux_in_ready = orphan | ~full[target];
    accept   = demux_in_valid & demux_in_ready;
    push     = '0;
    push[target] = accept & ~orphan;
    drop_inc = accept & (orphan | ((state_q == StPkt) & demux_in_startofpacket));
    state_d  = state_q;
    lock_d   = lock_q;
    if (accept && !orphan) begin
      if (demux_in_startofpacket) begin
        lock_d  = demux_in_channel;
        state_d = demux_in_endofpacket ? StIdle : StPkt;
      end else if (demux_in_endofpacket) begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= StIdle;
      lock_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      if (drop_inc && drop_q != '1) drop_q <= drop_q + 1'b1;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [EntW-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_q, rd_q;
    logic [OccW-1:0] occ_q;

    assign full[g]      = (occ_q == OccW'(FIFO_DEPTH));
    assign not_empty[g] = (occ_q != '0);
    assign pop[g]       = not_empty[g] & out_ready[g];
    // Gate the head so stale storage never leaks out while empty or in reset.
    assign head[g]      = not_empty[g] ? mem_q[rd_q] : '0;

    always_ff @(posedge clk_clk) begin
      if (push[g]) begin
        mem_q[wr_q] <= {demux_in_startofpacket, demux_in_endofpacket, demux_in_data};
      end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
        wr_q  <= '0;
        rd_q  <= '0;
        occ_q <= '0;
      end else begin
        if (push[g]) wr_q <= wr_q + 1'b1;
        if (pop[g])  rd_q <= rd_q + 1'b1;
        if (push[g] != pop[g]) occ_q <= push[g] ? occ_q + 1'b1 : occ_q - 1'b1;
      end
    end
  end

  assign demux_out0_valid         = not_empty[0];
  assign demux_out0_startofpacket = head[0][EntW-1];
  assign demux_out0_endofpacket   = head[0][EntW-2];
  assign demux_out0_data          = head[0][DATA_WIDTH-1:0];
  assign demux_out1_valid         = not_empty[1];
  assign demux_out1_startofpacket = head[1][EntW-1];
  assign demux_out1_endofpacket   = head[1][EntW-2];
  assign demux_out1_data          = head[1][DATA_WIDTH-1:0];
  assign drop_count               = drop_q;
  assign demux_busy               = (state_q == StPkt);

endmodule

// File: tb/tb_avalon_st_channel_demux.sv
// Bench for avalon_st_channel_demux: queue-based packet model checked every cycle,
// plus literal expectations for each directed scenario.
module tb_avalon_st_channel_demux;

  localparam int DW = 72;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk_clk = 0;
  logic          reset_reset_n = 0;
  logic [DW-1:0] in_data = '0;
  logic          in_channel = 0, in_sop = 0, in_eop = 0, in_valid = 0;
  logic          in_ready;
  logic [DW-1:0] out0_data, out1_data;
  logic          out0_sop, out0_eop, out0_valid, out1_sop, out1_eop, out1_valid;
  logic          out0_ready = 1, out1_ready = 1;
  logic [15:0]   drop_count;
  logic          busy;

  int n_tests = 0;
  int n_fail = 0;

  // Model state
  beat_t mq0[$], mq1[$];
  bit    m_open = 0;
  bit    m_lock = 0;
  int    m_drop = 0;
  // Beats actually delivered by the DUT
  beat_t rx0[$], rx1[$];
  bit    busy_seen = 0;

  avalon_st_channel_demux dut (
    .clk_clk                 (clk_clk),
    .reset_reset_n           (reset_reset_n),
    .demux_in_data           (in_data),
    .demux_in_channel        (in_channel),
    .demux_in_startofpacket  (in_sop),
    .demux_in_endofpacket    (in_eop),
    .demux_in_valid          (in_valid),
    .demux_in_ready          (in_ready),
    .demux_out0_data         (out0_data),
    .demux_out0_startofpacket(out0_sop),
    .demux_out0_endofpacket  (out0_eop),
    .demux_out0_valid        (out0_valid),
    .demux_out0_ready        (out0_ready),
    .demux_out1_data         (out1_data),
    .demux_out1_startofpacket(out1_sop),
    .demux_out1_endofpacket  (out1_eop),
    .demux_out1_valid        (out1_valid),
    .demux_out1_ready        (out1_ready),
    .drop_count              (drop_count),
    .demux_busy              (busy)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model_ready();
    bit tgt;
    if (!m_open && !in_sop) return 1'b1;
    tgt = (m_open && !in_sop) ? m_lock : in_channel;
    return tgt ? (mq1.size() < DEPTH) : (mq0.size() < DEPTH);
  endfunction

  // Model update on the active edge; inputs only change 2 time units after it.
  initial forever begin
    @(posedge clk_clk or negedge reset_reset_n);
    if (!reset_reset_n) begin
      mq0.delete();
      mq1.delete();
      m_open = 0;
      m_lock = 0;
      m_drop = 0;
    end else begin
      bit acc, tgt;
      acc = in_valid && model_ready();
      if (mq0.size() > 0 && out0_ready) void'(mq0.pop_front());
      if (mq1.size() > 0 && out1_ready) void'(mq1.pop_front());
      if (acc) begin
        if (!m_open && !in_sop) begin
          if (m_drop < 65535) m_drop++;
        end else begin
          if (m_open && in_sop && m_drop < 65535) m_drop++;
          tgt = in_sop ? in_channel : m_lock;
          if (tgt) mq1.push_back({in_sop, in_eop, in_data});
          else     mq0.push_back({in_sop, in_eop, in_data});
          if (in_sop) begin
            m_lock = in_channel;
            m_open = !in_eop;
          end else if (in_eop) begin
            m_open = 0;
          end
        end
      end
    end
  end

  // Per-cycle compare on the inactive edge.
  initial forever begin
    @(negedge clk_clk);
    if (reset_reset_n) begin
      check("in_ready", in_ready, model_ready());
      check("out0_valid", out0_valid, mq0.size() > 0);
      check("out1_valid", out1_valid, mq1.size() > 0);
      if (mq0.size() > 0 && out0_valid) check("out0_beat", {out0_sop, out0_eop, out0_data}, mq0[0]);
      if (mq1.size() > 0 && out1_valid) check("out1_beat", {out1_sop, out1_eop, out1_data}, mq1[0]);
      check("drop_count", drop_count, m_drop);
      check("busy", busy, m_open);
      if (busy) busy_seen = 1;
      if (out0_valid && out0_ready) rx0.push_back({out0_sop, out0_eop, out0_data});
      if (out1_valid && out1_ready) rx1.push_back({out1_sop, out1_eop, out1_data});
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_clk);
      #2;
    end
  endtask

  task automatic send(input logic ch, input logic sop, input logic eop, input logic [DW-1:0] d);
    bit done = 0;
    bit r;
    in_channel = ch;
    in_sop = sop;
    in_eop = eop;
    in_data = d;
    in_valid = 1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk_clk);
      r = in_ready;
      @(posedge clk_clk);
      #2;
      if (r) done = 1;
    end
    in_valid = 0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got no ready, expected ready within 200 cycles");
    end
  endtask

  initial begin
    int b0, b1;
    #200000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1;
    repeat (3) @(posedge clk_clk);
    #2 reset_reset_n = 1;
    check("reset_out0_valid", out0_valid, 0);
    check("reset_out1_valid", out1_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_drop", drop_count, 0);
    check("reset_out0_data", out0_data, 0);
    idle(1);

    // 4-beat packet on channel 1
    b0 = rx0.size(); b1 = rx1.size();
    for (int i = 0; i < 4; i++) send(1, i == 0, i == 3, DW'(i + 1));
    idle(4);
    check("t1_out1_count", rx1.size() - b1, 4);
    check("t1_out0_count", rx0.size() - b0, 0);
    for (int i = 0; i < 4; i++) begin
      check("t1_data", rx1[b1 + i].data, i + 1);
      check("t1_sop", rx1[b1 + i].sop, i == 0);
      check("t1_eop", rx1[b1 + i].eop, i == 3);
    end
    check("t1_drop", drop_count, 0);

    // Channel toggled mid-packet is ignored
    b0 = rx0.size(); b1 = rx1.size();
    for (int i = 0; i < 4; i++) send((i == 1 || i == 2), i == 0, i == 3, DW'(32'h20 + i));
    idle(4);
    check("t2_out0_count", rx0.size() - b0, 4);
    check("t2_out1_count", rx1.size() - b1, 0);
    check("t2_last", rx0[b0 + 3].data, 32'h23);

    // Backpressure on out0 during a 5-beat packet
    b0 = rx0.size();
    out0_ready = 0;
    send(0, 1, 0, DW'(32'h10));
    send(0, 0, 0, DW'(32'h11));
    in_sop = 0; in_eop = 0; in_channel = 0; in_data = DW'(32'h12); in_valid = 1;
    @(negedge clk_clk);
    check("t3_ready_low", in_ready, 0);
    check("t3_busy", busy, 1);
    @(posedge clk_clk);
    #2;
    fork
      begin
        idle(3);
        out0_ready = 1;
      end
      begin
        for (int i = 2; i < 5; i++) send(0, 0, i == 4, DW'(32'h10 + i));
      end
    join
    idle(4);
    check("t3_count", rx0.size() - b0, 5);
    for (int i = 0; i < 5; i++) check("t3_order", rx0[b0 + i].data, 32'h10 + i);

    // Orphan, then a packet whose second beat carries SOP on channel 1
    b0 = rx0.size(); b1 = rx1.size();
    send(0, 0, 0, DW'(32'h30));
    send(0, 1, 0, DW'(32'h31));
    send(1, 1, 0, DW'(32'h32));
    send(0, 0, 1, DW'(32'h33));
    idle(4);
    check("t4_drop", drop_count, 2);
    check("t4_out0_count", rx0.size() - b0, 1);
    check("t4_out1_count", rx1.size() - b1, 2);
    check("t4_out1_first", rx1[b1].data, 32'h32);
    check("t4_out1_second", rx1[b1 + 1].data, 32'h33);
    check("t4_busy", busy, 0);

    // Single-beat packets alternating channels
    b0 = rx0.size(); b1 = rx1.size();
    busy_seen = 0;
    for (int i = 0; i < 8; i++) send(i[0], 1, 1, DW'(32'h40 + i));
    idle(3);
    check("t5_out0_count", rx0.size() - b0, 4);
    check("t5_out1_count", rx1.size() - b1, 4);
    check("t5_out1_third", rx1[b1 + 2].data, 32'h45);
    check("t5_busy_seen", busy_seen, 0);

    // Asynchronous reset mid-packet with out0 FIFO full
    out0_ready = 0;
    send(0, 1, 0, DW'(32'h50));
    send(0, 0, 0, DW'(32'h51));
    in_sop = 0; in_data = DW'(32'h52); in_valid = 1;
    #1 reset_reset_n = 0;
    #1;
    check("t6_out0_valid", out0_valid, 0);
    check("t6_out1_valid", out1_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_drop", drop_count, 0);
    check("t6_out0_sop", out0_sop, 0);
    in_valid = 0;
    out0_ready = 1;
    @(posedge clk_clk);
    #2 reset_reset_n = 1;
    idle(1);
    b0 = rx0.size(); b1 = rx1.size();
    send(1, 1, 0, DW'(32'h60));
    send(1, 0, 1, DW'(32'h61));
    idle(4);
    check("t6_out0_after", rx0.size() - b0, 0);
    check("t6_out1_after", rx1.size() - b1, 2);
    check("t6_out1_data", rx1[b1 + 1].data, 32'h61);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
